// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter in front of a single SPI master.
// It pushes a new config to the master only when the winner's mode/width differs from
// the config last applied. Each transfer runs START, then WAIT, then returns dout and a
// timeout flag to the requester that won.
module spi_master_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int TIMEOUT_LOG       = 12,
  localparam int DW = 2**SPI_MAX_WIDTH_LOG,
  localparam int CW = SPI_MAX_WIDTH_LOG + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*CW-1:0] req_cfg,
  input  logic [NUM_REQ*DW-1:0] req_din,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_err,
  output logic [DW-1:0]         rsp_dout,
  output logic                  config_req,
  output logic [CW-1:0]         config_data,
  output logic                  spi_start,
  input  logic                  spi_finish,
  output logic [DW-1:0]         spi_din,
  input  logic [DW-1:0]         spi_dout
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, CFG, START, WAIT} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d, rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          cfg_q, cfg_d, cur_cfg_q, cur_cfg_d;
  logic [DW-1:0]          din_q, din_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic [TIMEOUT_LOG-1:0] wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [DW-1:0]          rsp_dout_q, rsp_dout_d;
  logic                   config_req_q, config_req_d;
  logic [CW-1:0]          config_data_q, config_data_d;
  logic                   spi_start_q, spi_start_d;
  logic [DW-1:0]          spi_din_q, spi_din_d;

  logic                   win_found;
  logic [IW-1:0]          win_idx;

  // Winner search: first set request starting at rr_ptr, wrapping at NUM_REQ-1 (not 2**IW-1).
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  // Next-state and registered-output logic; the pulse outputs default to 0 on every cycle.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rr_ptr_d      = rr_ptr_q;
    cfg_d         = cfg_q;
    cur_cfg_d     = cur_cfg_q;
    din_d         = din_q;
    cfg_valid_d   = cfg_valid_q;
    wait_cnt_d    = wait_cnt_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_err_d     = rsp_err_q;
    rsp_dout_d    = rsp_dout_q;
    config_req_d  = 1'b0;
    config_data_d = config_data_q;
    spi_start_d   = 1'b0;
    spi_din_d     = spi_din_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          idx_d                = win_idx;
          cfg_d                = req_cfg[int'(win_idx)*CW +: CW];
          din_d                = req_din[int'(win_idx)*DW +: DW];
          req_ready_d[win_idx] = 1'b1;
          state_d = (!cfg_valid_q || cfg_d != cur_cfg_q) ? CFG : START;
        end
      end
      CFG: begin
        config_req_d  = 1'b1;
        config_data_d = cfg_q;
        cur_cfg_d     = cfg_q;
        cfg_valid_d   = 1'b1;
        state_d       = START;
      end
      START: begin
        spi_start_d = 1'b1;
        spi_din_d   = din_q;
        wait_cnt_d  = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + TIMEOUT_LOG'(1);
        if (spi_finish || (&wait_cnt_q)) begin
          // A finish arriving together with the timeout is still a good transfer.
          if (spi_finish) begin
            rsp_dout_d = spi_dout;
            rsp_err_d  = 1'b0;
          end else begin
            rsp_dout_d  = '0;
            rsp_err_d   = 1'b1;
            cfg_valid_d = 1'b0;
          end
          rsp_valid_d[idx_q] = 1'b1;
          rr_ptr_d = (idx_q == IW'(NUM_REQ-1)) ? '0 : idx_q + IW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer without sending a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      rr_ptr_q      <= '0;
      cfg_q         <= '0;
      cur_cfg_q     <= '0;
      din_q         <= '0;
      cfg_valid_q   <= 1'b0;
      wait_cnt_q    <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_dout_q    <= '0;
      config_req_q  <= 1'b0;
      config_data_q <= '0;
      spi_start_q   <= 1'b0;
      spi_din_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rr_ptr_q      <= rr_ptr_d;
      cfg_q         <= cfg_d;
      cur_cfg_q     <= cur_cfg_d;
      din_q         <= din_d;
      cfg_valid_q   <= cfg_valid_d;
      wait_cnt_q    <= wait_cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_dout_q    <= rsp_dout_d;
      config_req_q  <= config_req_d;
      config_data_q <= config_data_d;
      spi_start_q   <= spi_start_d;
      spi_din_q     <= spi_din_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_dout    = rsp_dout_q;
  assign config_req  = config_req_q;
  assign config_data = config_data_q;
  assign spi_start   = spi_start_q;
  assign spi_din     = spi_din_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter. The driver predicts each grant from a simple
// round-robin/config model and queues the expected transaction. A slave process answers
// spi_start. A monitor checks every DUT output against the head of the queue.
module tb_spi_master_arbiter;
  localparam int N  = 4;
  localparam int WL = 4;
  localparam int TL = 4;
  localparam int DW = 2**WL;
  localparam int CW = WL + 2;

  logic            clk, rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*CW-1:0] req_cfg;
  logic [N*DW-1:0] req_din;
  logic            rsp_err, config_req, spi_start, spi_finish;
  logic [DW-1:0]   rsp_dout, spi_din, spi_dout;
  logic [CW-1:0]   config_data;

  spi_master_arbiter #(.NUM_REQ(N), .SPI_MAX_WIDTH_LOG(WL), .TIMEOUT_LOG(TL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cfg(req_cfg), .req_din(req_din),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_dout(rsp_dout),
    .config_req(config_req), .config_data(config_data), .spi_start(spi_start),
    .spi_finish(spi_finish), .spi_din(spi_din), .spi_dout(spi_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] cfg_a [N];
  logic [DW-1:0] din_a [N];
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_cfg[g*CW +: CW] = cfg_a[g];
    assign req_din[g*DW +: DW] = din_a[g];
  end

  typedef struct {
    int idx; logic [CW-1:0] cfg; logic [DW-1:0] din; bit need;
    logic [DW-1:0] dout; bit err; int delay;
  } exp_t;
  typedef struct { bit hang; int delay; logic [DW-1:0] dout; } plan_t;

  exp_t  exp_q [$];
  plan_t plan_q [$];
  int n_cmp = 0, n_bad = 0;

  // Reference model state: pointer, last applied config and its validity.
  int            m_rr;
  bit            m_cv;
  logic [CW-1:0] m_cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: output with no transaction outstanding", nm);
  endtask

  function automatic int pick(input logic [N-1:0] p);
    for (int k = 0; k < N; k++)
      if (p[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  // Predict one transaction for requester w, queue it for the monitor/slave, advance the model.
  task automatic issue(input int w, input bit hang, input int dout_fix);
    exp_t e; plan_t p;
    p.hang  = hang;
    p.delay = $urandom_range(6);
    p.dout  = (dout_fix < 0) ? DW'($urandom) : DW'(dout_fix);
    e.idx = w; e.cfg = cfg_a[w]; e.din = din_a[w];
    e.need = !m_cv || (cfg_a[w] != m_cur);
    e.err = hang; e.dout = hang ? '0 : p.dout; e.delay = p.delay;
    m_cur = cfg_a[w];
    m_cv  = !hang;
    m_rr  = (w + 1) % N;
    exp_q.push_back(e);
    plan_q.push_back(p);
  endtask

  task automatic do_reset(input bit check_outs);
    rst = 1'b1;
    req_valid = '0;
    #1;
    if (check_outs) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_dout", rsp_dout, 0);
      chk("rst_config_req", config_req, 0);
      chk("rst_config_data", config_data, 0);
      chk("rst_spi_start", spi_start, 0);
      chk("rst_spi_din", spi_din, 0);
    end
    exp_q.delete();
    plan_q.delete();
    m_rr = 0; m_cv = 0; m_cur = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (req_ready == '0 && t < 100);
    ok = (req_ready != '0);
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  // Serve every requester in pat; optional random timeouts and withdrawals of losers.
  task automatic run(input logic [N-1:0] pat, input int hang_pct, input bit wd, input int dout_fix);
    logic [N-1:0] pend;
    int w, k0, t;
    bit ok;
    pend = pat;
    req_valid = pend;
    while (pend != '0) begin
      w = pick(pend);
      issue(w, $urandom_range(99) < hang_pct, dout_fix);
      wait_ready(ok);
      if (!ok) begin do_reset(0); return; end
      pend[w] = 1'b0;
      if (wd && pend != '0 && $urandom_range(3) == 0) begin
        k0 = $urandom_range(N-1);
        for (int k = 0; k < N; k++)
          if (pend[(k0 + k) % N]) begin pend[(k0 + k) % N] = 1'b0; break; end
      end
      req_valid = pend;
    end
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin chk("rsp_timeout", exp_q.size(), 0); do_reset(0); end
    @(negedge clk);
  endtask

  // Slave side of the master: answers each spi_start per the queued plan.
  initial begin
    plan_t p;
    spi_finish = 1'b0;
    spi_dout   = '0;
    forever begin
      @(negedge clk);
      spi_dout = DW'($urandom);
      if (!rst && spi_start && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        if (!p.hang) begin
          repeat (p.delay) begin @(negedge clk); spi_dout = DW'($urandom); end
          spi_dout   = p.dout;
          spi_finish = 1'b1;
          @(negedge clk);
          spi_finish = 1'b0;
          spi_dout   = DW'($urandom);
        end
      end
    end
  end

  // Monitor: compare every visible output event with the head of the scoreboard.
  int cyc = 0, rdy_cyc = 0, start_cyc = 0;
  bit busy = 0, cfg_seen = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      busy = 0; cfg_seen = 0;
    end else begin
      if (req_ready != '0) begin
        if (exp_q.size() == 0) fail_now("unexpected_ready");
        else begin
          chk("grant_idx", req_ready, 32'(1) << exp_q[0].idx);
          rdy_cyc = cyc; cfg_seen = 0;
        end
      end
      if (config_req) begin
        if (exp_q.size() == 0) fail_now("unexpected_config");
        else begin
          chk("cfg_needed", 1, exp_q[0].need);
          chk("config_data", config_data, exp_q[0].cfg);
          chk("cfg_latency", cyc - rdy_cyc, 1);
          cfg_seen = 1;
        end
      end
      if (spi_start) begin
        if (exp_q.size() == 0) fail_now("unexpected_start");
        else begin
          chk("start_latency", cyc - rdy_cyc, exp_q[0].need ? 2 : 1);
          chk("cfg_before_start", cfg_seen, exp_q[0].need);
          chk("spi_din", spi_din, exp_q[0].din);
          start_cyc = cyc; busy = 1;
        end
      end else if (busy && exp_q.size() > 0) begin
        chk("spi_din_hold", spi_din, exp_q[0].din);
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) fail_now("unexpected_rsp");
        else begin
          e = exp_q.pop_front();
          chk("rsp_idx", rsp_valid, 32'(1) << e.idx);
          chk("rsp_dout", rsp_dout, e.dout);
          chk("rsp_err", rsp_err, e.err);
          if (!e.err) chk("rsp_latency", cyc - start_cyc, e.delay + 1);
          else chk("timeout_window", (cyc - start_cyc >= 15) && (cyc - start_cyc <= 17), 1);
          busy = 0;
        end
      end
    end
  end

  initial begin
    bit ok;
    int t;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin cfg_a[i] = 6'h2F; din_a[i] = DW'($urandom); end
    m_rr = 0; m_cv = 0; m_cur = '0;
    do_reset(1);

    // First transfer reconfigures; the repeat with the same cfg does not.
    cfg_a[0] = 6'h2F; din_a[0] = 16'hA5C3;
    run(4'b0001, 0, 0, 16'h3C5A);
    run(4'b0001, 0, 0, -1);

    // Fresh pointer: held 1111 grants 0,1,2,3, then 0 again.
    do_reset(0);
    run(4'b1111, 0, 0, -1);
    run(4'b0001, 0, 0, -1);
    // Pointer at 2 with 0011 pending wraps to 0.
    run(4'b0010, 0, 0, -1);
    run(4'b0011, 0, 0, -1);

    // Width change then change back: config before each.
    cfg_a[1] = 6'h27; cfg_a[2] = 6'h2F;
    run(4'b0010, 0, 0, -1);
    run(4'b0100, 0, 0, -1);

    // Timeout, then the same cfg has to be pushed again.
    run(4'b0100, 100, 0, -1);
    run(4'b0100, 0, 0, -1);

    // Reset during WAIT clears all outputs at once and invalidates the config.
    req_valid = 4'b0001;
    issue(0, 1'b1, -1);
    wait_ready(ok);
    req_valid = '0;
    t = 0;
    while (!busy && t < 20) begin @(negedge clk); t++; end
    chk("reached_wait", busy, 1);
    repeat (3) @(negedge clk);
    #2;
    do_reset(1);
    run(4'b0100, 0, 0, -1);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(3))
          0: cfg_a[i] = 6'h27;
          1: cfg_a[i] = 6'h2F;
          2: cfg_a[i] = 6'h1F;
          default: cfg_a[i] = 6'h0B;
        endcase
        din_a[i] = DW'($urandom);
      end
      run(N'($urandom_range(15)), 10, 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
